// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// alu_issue_stage : EX issue register ahead of a combinational ALU, with
//                   EX->EX forwarding. Optional one-hot opcode check is
//                   enabled by defining ALU_ISSUE_OPCHK_EN.
// Revision        : 1.0
// ============================================================================
module alu_issue_stage #(
   parameter int XLEN = 64,
   parameter int OPW  = 12,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ds_valid,
   output logic            es_allowin,
   input  logic [OPW-1:0]  ds_alu_op,
   input  logic [XLEN-1:0] ds_rs1_val,
   input  logic [XLEN-1:0] ds_rs2_val,
   input  logic [RAW-1:0]  ds_rs1_addr,
   input  logic [RAW-1:0]  ds_rs2_addr,
   input  logic [XLEN-1:0] ds_imm,
   input  logic [XLEN-1:0] ds_pc,
   input  logic            ds_src1_is_pc,
   input  logic            ds_src2_is_imm,
   input  logic [RAW-1:0]  ds_rd,
   output logic [OPW-1:0]  alu_op,
   output logic [XLEN-1:0] alu_src1,
   output logic [XLEN-1:0] alu_src2,
   input  logic [XLEN-1:0] alu_result,
   input  logic            ms_allowin,
   output logic            es_to_ms_valid,
   output logic [XLEN-1:0] es_result,
   output logic [RAW-1:0]  es_rd,
   output logic            es_op_err
);

   logic            r_es_valid;
   logic [OPW-1:0]  r_alu_op;
   logic [XLEN-1:0] r_alu_src1;
   logic [XLEN-1:0] r_alu_src2;
   logic [RAW-1:0]  r_es_rd;

   logic            w_es_allowin;
   logic            w_accept;
   logic            w_fwd1_hit;
   logic            w_fwd2_hit;
   logic [XLEN-1:0] w_fwd1;
   logic [XLEN-1:0] w_fwd2;
   logic [XLEN-1:0] w_src1;
   logic [XLEN-1:0] w_src2;
   logic [OPW-1:0]  w_op_lat;

   assign w_es_allowin = !r_es_valid || ms_allowin;
   assign w_accept     = ds_valid && w_es_allowin;

   // Accepting while EX is valid implies the older instruction leaves on this
   // same edge, so its ALU result can be taken directly as the operand.
   assign w_fwd1_hit = r_es_valid && (r_es_rd != '0) && (r_es_rd == ds_rs1_addr);
   assign w_fwd2_hit = r_es_valid && (r_es_rd != '0) && (r_es_rd == ds_rs2_addr);
   assign w_fwd1     = w_fwd1_hit ? alu_result : ds_rs1_val;
   assign w_fwd2     = w_fwd2_hit ? alu_result : ds_rs2_val;
   assign w_src1     = ds_src1_is_pc  ? ds_pc  : w_fwd1;
   assign w_src2     = ds_src2_is_imm ? ds_imm : w_fwd2;

`ifdef ALU_ISSUE_OPCHK_EN
   logic w_op_ok;
   logic r_es_op_err;

   assign w_op_ok  = (ds_alu_op != '0) && ((ds_alu_op & (ds_alu_op - OPW'(1))) == '0);
   assign w_op_lat = w_op_ok ? ds_alu_op : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_es_op_err <= 1'b0;
      end else if (w_accept) begin
         r_es_op_err <= !w_op_ok;
      end
   end

   assign es_op_err = r_es_op_err;
`else
   assign w_op_lat  = ds_alu_op;
   assign es_op_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_es_valid <= 1'b0;
         r_alu_op   <= '0;
         r_alu_src1 <= '0;
         r_alu_src2 <= '0;
         r_es_rd    <= '0;
      end else if (w_es_allowin) begin
         r_es_valid <= ds_valid;
         if (ds_valid) begin
            r_alu_op   <= w_op_lat;
            r_alu_src1 <= w_src1;
            r_alu_src2 <= w_src2;
            r_es_rd    <= ds_rd;
         end
      end
   end

   assign es_allowin     = w_es_allowin;
   assign es_to_ms_valid = r_es_valid;
   assign alu_op         = r_alu_op;
   assign alu_src1       = r_alu_src1;
   assign alu_src2       = r_alu_src2;
   assign es_result      = alu_result;
   assign es_rd          = r_es_rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_stage : directed self-checking bench for alu_issue_stage with a
//                      small behavioural ALU closing the loop.
// Revision           : 1.0
// ============================================================================
module tb_alu_issue_stage;

   localparam int XLEN = 64;
   localparam int OPW  = 12;
   localparam int RAW  = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            ds_valid;
   logic            es_allowin;
   logic [OPW-1:0]  ds_alu_op;
   logic [XLEN-1:0] ds_rs1_val, ds_rs2_val, ds_imm, ds_pc;
   logic [RAW-1:0]  ds_rs1_addr, ds_rs2_addr, ds_rd;
   logic            ds_src1_is_pc, ds_src2_is_imm;
   logic [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_src1, alu_src2, alu_result, es_result;
   logic            ms_allowin, es_to_ms_valid, es_op_err;
   logic [RAW-1:0]  es_rd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(XLEN), .OPW(OPW), .RAW(RAW)) dut (
      .clk(clk), .reset(reset), .ds_valid(ds_valid), .es_allowin(es_allowin),
      .ds_alu_op(ds_alu_op), .ds_rs1_val(ds_rs1_val), .ds_rs2_val(ds_rs2_val),
      .ds_rs1_addr(ds_rs1_addr), .ds_rs2_addr(ds_rs2_addr), .ds_imm(ds_imm),
      .ds_pc(ds_pc), .ds_src1_is_pc(ds_src1_is_pc), .ds_src2_is_imm(ds_src2_is_imm),
      .ds_rd(ds_rd), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_result(alu_result), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
      .es_result(es_result), .es_rd(es_rd), .es_op_err(es_op_err)
   );

   // Behavioural ALU: add, sub, and, or, ..., xor on the top bit; anything else yields 0.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         12'd1:    alu_result = alu_src1 + alu_src2;
         12'd2:    alu_result = alu_src1 - alu_src2;
         12'd4:    alu_result = alu_src1 & alu_src2;
         12'd8:    alu_result = alu_src1 | alu_src2;
         12'd2048: alu_result = alu_src1 ^ alu_src2;
         default:  alu_result = '0;
      endcase
   end

   task automatic drive(input logic v, input logic [OPW-1:0] op,
                        input logic [RAW-1:0] a1, input logic [XLEN-1:0] v1,
                        input logic [RAW-1:0] a2, input logic [XLEN-1:0] v2,
                        input logic [RAW-1:0] rd);
      ds_valid       = v;
      ds_alu_op      = op;
      ds_rs1_addr    = a1;
      ds_rs1_val     = v1;
      ds_rs2_addr    = a2;
      ds_rs2_val     = v2;
      ds_rd          = rd;
      ds_src1_is_pc  = 1'b0;
      ds_src2_is_imm = 1'b0;
      ds_imm         = '0;
      ds_pc          = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ms_allowin = 1'b1;
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
      tick();
      n_tests++; if (es_to_ms_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", es_to_ms_valid); end
      n_tests++; if (es_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %0b want 1", es_allowin); end
      n_tests++; if (alu_op !== 12'd0 || alu_src1 !== 64'd0 || alu_src2 !== 64'd0) begin
         n_fail++; $display("FAIL reset_alu got op=%0h s1=%0h s2=%0h want 0", alu_op, alu_src1, alu_src2); end
      n_tests++; if (es_rd !== 5'd0 || es_op_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd_err got rd=%0d err=%0b want 0", es_rd, es_op_err); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      drive(1'b1, 12'd1, 5'd1, 64'd288, 5'd2, 64'd77, 5'd3);
      tick();
      n_tests++; if (alu_op !== 12'd1 || alu_src1 !== 64'd288 || alu_src2 !== 64'd77) begin
         n_fail++; $display("FAIL basic_ops got op=%0d s1=%0d s2=%0d want 1/288/77", alu_op, alu_src1, alu_src2); end
      n_tests++; if (es_to_ms_valid !== 1'b1 || es_result !== 64'd365 || es_rd !== 5'd3) begin
         n_fail++; $display("FAIL basic_out got v=%0b res=%0d rd=%0d want 1/365/3", es_to_ms_valid, es_result, es_rd); end
      drive(1'b0, 12'd2, 5'd1, 64'd9, 5'd2, 64'd9, 5'd4);
      tick();
      n_tests++; if (es_to_ms_valid !== 1'b0 || alu_src1 !== 64'd288 || alu_op !== 12'd1) begin
         n_fail++; $display("FAIL bubble_hold got v=%0b s1=%0d op=%0d want 0/288/1", es_to_ms_valid, alu_src1, alu_op); end
   endtask

   task automatic test_imm_pc();
      drive(1'b1, 12'd1, 5'd1, 64'd11, 5'd2, 64'd22, 5'd6);
      ds_src1_is_pc  = 1'b1;
      ds_pc          = 64'h1000;
      ds_src2_is_imm = 1'b1;
      ds_imm         = -64'sd300;
      tick();
      n_tests++; if (alu_src1 !== 64'h1000 || alu_src2 !== 64'hFFFF_FFFF_FFFF_FED4) begin
         n_fail++; $display("FAIL imm_pc got s1=%0h s2=%0h want 1000/fffffffffffffed4", alu_src1, alu_src2); end
      n_tests++; if (es_result !== 64'h0ED4) begin
         n_fail++; $display("FAIL imm_pc_res got %0h want ed4", es_result); end
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_forward();
      drive(1'b1, 12'd1, 5'd1, 64'd288, 5'd2, 64'd77, 5'd5);
      tick();
      drive(1'b1, 12'd2, 5'd5, 64'd0, 5'd6, 64'd10, 5'd7);
      tick();
      n_tests++; if (alu_src1 !== 64'd365 || alu_src2 !== 64'd10 || es_result !== 64'd355) begin
         n_fail++; $display("FAIL fwd_rs1 got s1=%0d s2=%0d res=%0d want 365/10/355", alu_src1, alu_src2, es_result); end
      drive(1'b1, 12'd1, 5'd7, 64'd1, 5'd7, 64'd2, 5'd8);
      tick();
      n_tests++; if (alu_src1 !== 64'd355 || alu_src2 !== 64'd355) begin
         n_fail++; $display("FAIL fwd_both got s1=%0d s2=%0d want 355/355", alu_src1, alu_src2); end
      drive(1'b1, 12'd1, 5'd1, 64'd288, 5'd2, 64'd77, 5'd0);
      tick();
      drive(1'b1, 12'd2, 5'd0, 64'd0, 5'd0, 64'd0, 5'd9);
      tick();
      n_tests++; if (alu_src1 !== 64'd0 || alu_src2 !== 64'd0) begin
         n_fail++; $display("FAIL fwd_r0 got s1=%0d s2=%0d want 0/0", alu_src1, alu_src2); end
      drive(1'b1, 12'd1, 5'd1, 64'd40, 5'd2, 64'd2, 5'd5);
      tick();
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
      drive(1'b1, 12'd8, 5'd5, 64'd7, 5'd4, 64'd8, 5'd10);
      tick();
      n_tests++; if (alu_src1 !== 64'd7 || es_result !== 64'd15) begin
         n_fail++; $display("FAIL fwd_invalid got s1=%0d res=%0d want 7/15", alu_src1, es_result); end
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_stall();
      drive(1'b1, 12'd1, 5'd1, 64'd100, 5'd2, 64'd1, 5'd7);
      tick();
      ms_allowin = 1'b0;
      drive(1'b1, 12'd4, 5'd0, 64'hF0, 5'd0, 64'h3C, 5'd8);
      #1;
      n_tests++; if (es_allowin !== 1'b0) begin
         n_fail++; $display("FAIL stall_allowin got %0b want 0", es_allowin); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (alu_op !== 12'd1 || alu_src1 !== 64'd100 || alu_src2 !== 64'd1 ||
                        es_result !== 64'd101 || es_to_ms_valid !== 1'b1 || es_rd !== 5'd7) begin
            n_fail++; $display("FAIL stall_hold%0d got op=%0d s1=%0d s2=%0d res=%0d v=%0b rd=%0d want 1/100/1/101/1/7",
                               i, alu_op, alu_src1, alu_src2, es_result, es_to_ms_valid, es_rd); end
      end
      ms_allowin = 1'b1;
      tick();
      n_tests++; if (alu_op !== 12'd4 || alu_src1 !== 64'hF0 || alu_src2 !== 64'h3C ||
                     es_result !== 64'h30 || es_rd !== 5'd8) begin
         n_fail++; $display("FAIL stall_release got op=%0d s1=%0h s2=%0h res=%0h rd=%0d want 4/f0/3c/30/8",
                            alu_op, alu_src1, alu_src2, es_result, es_rd); end
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_opchk();
      drive(1'b1, 12'd3, 5'd1, 64'd5, 5'd2, 64'd6, 5'd1);
      tick();
`ifdef ALU_ISSUE_OPCHK_EN
      n_tests++; if (alu_op !== 12'd0 || es_result !== 64'd0 || es_op_err !== 1'b1) begin
         n_fail++; $display("FAIL opchk_3 got op=%0d res=%0d err=%0b want 0/0/1", alu_op, es_result, es_op_err); end
      drive(1'b1, 12'd0, 5'd0, 64'd5, 5'd0, 64'd6, 5'd2);
      tick();
      n_tests++; if (es_op_err !== 1'b1) begin
         n_fail++; $display("FAIL opchk_0 got err=%0b want 1", es_op_err); end
      drive(1'b1, 12'd2048, 5'd0, 64'd5, 5'd0, 64'd6, 5'd3);
      tick();
      n_tests++; if (es_op_err !== 1'b0 || alu_op !== 12'd2048 || es_result !== 64'd3) begin
         n_fail++; $display("FAIL opchk_2048 got err=%0b op=%0d res=%0d want 0/2048/3", es_op_err, alu_op, es_result); end
`else
      n_tests++; if (alu_op !== 12'd3 || es_op_err !== 1'b0) begin
         n_fail++; $display("FAIL opchk_off got op=%0d err=%0b want 3/0", alu_op, es_op_err); end
`endif
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 12'd1, 5'd1, 64'd50, 5'd2, 64'd60, 5'd4);
      tick();
      ms_allowin = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_tests++; if (es_to_ms_valid !== 1'b0 || alu_op !== 12'd0 || es_allowin !== 1'b1) begin
         n_fail++; $display("FAIL async_reset got v=%0b op=%0d allowin=%0b want 0/0/1", es_to_ms_valid, alu_op, es_allowin); end
      tick();
      reset = 1'b0;
      ms_allowin = 1'b1;
      drive(1'b0, '0, '0, '0, '0, '0, '0);
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_imm_pc();
      test_forward();
      test_stall();
      test_opchk();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage sitting directly upstream of the combinational 64-bit ALU (12-bit one-hot alu_op, alu_src1, alu_src2 -> alu_result).
- Accepts decoded instructions from decode over a valid/allowin handshake, selects the operands and latches them into the EX register.
- Drives the ALU from that register and hands the ALU result to memory stage over the same handshake.
- Provides EX->EX forwarding for back-to-back dependent instructions.

Parameters:
- XLEN, 64, datapath width of operands and result.
- OPW, 12, width of one-hot ALU opcode.
- RAW, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ds_valid  input  1  decode presents an instruction.
- es_allowin  output  1  stage can accept this cycle.
- ds_alu_op  input  OPW  one-hot ALU opcode.
- ds_rs1_val, ds_rs2_val  input  XLEN  register-file read data.
- ds_rs1_addr, ds_rs2_addr  input  RAW  source register numbers.
- ds_imm, ds_pc  input  XLEN  immediate, instruction PC.
- ds_src1_is_pc, ds_src2_is_imm  input  1  operand selects.
- ds_rd  input  RAW  destination register, 0 = no write.
- alu_op  output  OPW  to ALU.
- alu_src1, alu_src2  output  XLEN  to ALU.
- alu_result  input  XLEN  from ALU.
- ms_allowin  input  1  memory stage can accept.
- es_to_ms_valid  output  1  result valid toward memory stage.
- es_result  output  XLEN  = alu_result.
- es_rd  output  RAW  destination of the instruction in EX.
- es_op_err  output  1  the instruction in EX carried a non-one-hot opcode (feature-gated).

Behaviour:
- Reset (async, immediate): es_valid=0, alu_op=0, alu_src1=0, alu_src2=0, es_rd=0, es_op_err=0. Hence es_to_ms_valid=0 and es_allowin=1.
- es_ready_go=1, so latency is 1 cycle: an instruction accepted at edge N appears on the alu_* outputs and es_result during cycle N..N+1.
- es_allowin = !es_valid || ms_allowin. This is combinational and has no dependence on ds_valid.
- es_to_ms_valid = es_valid.
- Accept when ds_valid && es_allowin:
  - es_valid<=1.
  - Latch the opcode, the selected operands and ds_rd.
  - If es_allowin && !ds_valid: es_valid<=0 and the data registers hold their values.
- Stall when es_valid && !ms_allowin: all registers hold. alu_op, alu_src1 and alu_src2 stay stable, so es_result stays stable.
- Operand select:
  - src1 = ds_src1_is_pc ? ds_pc : fwd1.
  - src2 = ds_src2_is_imm ? ds_imm : fwd2.
- Forwarding: fwdX = alu_result when es_valid && es_rd!=0 && es_rd==ds_rsX_addr; otherwise ds_rsX_val.
  - The forward path is evaluated only on accept. Because es_valid at accept time implies ms_allowin, the older instruction is leaving in the same edge.
- When both sources hit the same rd, both are forwarded.
- Register 0 is never forwarded.
- Opcode check is combinational: ok = (ds_alu_op != 0) && ((ds_alu_op & (ds_alu_op-1)) == 0).
- No other state. There is no flush input; reset is the only way to abort an in-flight instruction.

Optional Feature:
- Macro ALU_ISSUE_OPCHK_EN.
- Defined:
  - A non-one-hot ds_alu_op is latched as alu_op=0, which gives an ALU result of 0.
  - es_op_err<=1 for that instruction. es_op_err follows the same hold/advance rules as es_rd.
- Undefined:
  - ds_alu_op is latched unchanged.
  - es_op_err is tied to 0.
  - No check logic is instantiated.

Test Plan:
- Reset mid-flight: hold reset high with es_valid=1 -> es_to_ms_valid=0, alu_op=0, es_allowin=1 immediately, without waiting for a clock edge.
- Basic issue: ds_alu_op=12'd1, rs1=288, rs2=77, ms_allowin=1 -> next cycle alu_op=1, alu_src1=288, alu_src2=77, es_to_ms_valid=1, es_result=365.
- Immediate/PC select: ds_src1_is_pc=1, pc=0x1000, ds_src2_is_imm=1, imm=-300 -> alu_src1=0x1000, alu_src2=64'hFFFF_FFFF_FFFF_FED4.
- Back-to-back forward:
  - Issue add rd=5 with 288+77.
  - Next cycle issue op 12'd2 with rs1_addr=5, rs1_val=0 (stale).
  - Required: alu_src1=365.
  - Repeat with rd=0: alu_src1=0 (not forwarded).
- Stall: ms_allowin=0 while es_valid=1, with ds_valid=1 and new operands -> es_allowin=0; alu_* and es_result unchanged for 3 cycles; the held instruction advances on the cycle ms_allowin returns to 1.
- ALU_ISSUE_OPCHK_EN defined: ds_alu_op=12'd3 -> alu_op=0, es_result=0, es_op_err=1. ds_alu_op=0 -> es_op_err=1. ds_alu_op=12'd2048 -> es_op_err=0.
